muldiv_ctrl: RTL
================

# muldiv_ctrl

Multi-cycle sequencer for signed MULT/DIV in the multicycle MIPS core. It accepts a one-cycle start request from `controlador`, latches the two operands from registers A and B, and iterates a shift-add multiply or restoring divide over 32 cycles. It then owns the architectural Hi/Lo registers read by MFHI/MFLO. The main controller holds in a wait state until `Done`.

## Interface
Parameters
- `WIDTH`, 32, operand width; the iteration count equals `WIDTH`.

Ports
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Start` in 1: request, sampled on the rising edge.
- `Op` in 1: 0 = MULT (signed), 1 = DIV (signed).
- `OpA` in WIDTH: multiplicand or dividend (register A output).
- `OpB` in WIDTH: multiplier or divisor (register B output).
- `Busy` out 1: high while an operation is in flight.
- `Done` out 1: one-cycle completion pulse.
- `DivZero` out 1: pulses with `Done` when a DIV had a zero divisor.
- `Hi` out WIDTH: MULT upper product half, or DIV remainder.
- `Lo` out WIDTH: MULT lower product half, or DIV quotient.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE, `Start`=1:
  - latch `Op`, |OpA|, |OpB|, `sA`=OpA[31], `sB`=OpB[31];
  - clear the 64-bit work register and the 5-bit counter;
  - go to RUN.
  - Exception: DIV with OpB==0 goes directly to FIX with a zero-divide flag set.
- IDLE or DONE, `Start`=0: DONE returns to IDLE; IDLE stays.
- RUN, MULT: each cycle, if the multiplier LSB is 1, add the multiplicand into the upper work half. Then shift {carry, work} right 1 and shift the multiplier right 1.
- RUN, DIV: each cycle, shift {rem, quot} left 1 and trial-subtract the divisor from rem.
  - Non-negative result: keep it, set the quotient LSB to 1.
  - Negative result: restore rem, quotient LSB is 0.
- RUN exit: the counter increments each RUN cycle; RUN goes to FIX when counter==31, after 32 iterations.
- FIX, MULT: if sA^sB, two's-complement the 64-bit product. Hi=product[63:32], Lo=product[31:0].
- FIX, DIV: quotient negated if sA^sB; remainder negated if sA. Hi=rem, Lo=quot.
- FIX, DIV by zero: Hi and Lo are not written.
- FIX always goes to DONE.
- DONE: `Done`=1 and, if flagged, `DivZero`=1.
- `Start` while in RUN or FIX is ignored; no queuing.
- Arithmetic rules:
  - absolute value of 0x80000000 is 0x80000000, treated as an unsigned magnitude;
  - products and quotients wrap modulo 2^64 or 2^32;
  - 0x80000000 / 0xFFFFFFFF yields Lo=0x80000000, Hi=0, with no flag.
- `Hi`/`Lo` hold their value from FIX until the next completing FIX. They are never cleared except by Reset.

## Timing
- Reset (asynchronous, any state including mid-RUN):
  - state=IDLE, `Busy`=`Done`=`DivZero`=0, `Hi`=`Lo`=0;
  - counter and work registers = 0;
  - the in-flight operation is discarded with no `Done`.
- Latency: call the edge that samples `Start` E0.
  - RUN covers E1..E32.
  - FIX writes Hi/Lo at edge E33.
  - `Done` is high between E33 and E34.
- Zero-divide path: FIX at E1, `Done` between E1 and E2.
- `Busy`=1 in RUN and FIX, and 0 in IDLE and DONE.
- `Done` is never high for more than one cycle per operation.
- `Start` in DONE is accepted: back-to-back operations have a 34-edge period.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg`:
  - enum `muldiv_state_t` {IDLE, RUN, FIX, DONE};
  - constants `OP_MULT`=1'b0 and `OP_DIV`=1'b1;
  - `MULDIV_ITER`=32.
- `controlador` imports the same op constants.
- One sub-module: `neg_if`, a combinational conditional two's-complement (width-parameterised). It is instantiated for operand absolute values and for result sign fix-up.
- The FSM and the shift/add datapath stay in `muldiv_ctrl`.

## Test plan
- MULT 11×3, Start at E0 -> `Done` between E33 and E34, Hi=0x00000000, Lo=0x00000021, `Busy` high for E1..E33.
- MULT 0xFFFFFFFE×3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. MULT 0x80000000×0x80000000 -> Hi=0x40000000, Lo=0.
- DIV 0xFFFFFFF9/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIV 5/0 with prior Hi/Lo = 0x12/0x34 -> `Done`=`DivZero`=1 between E1 and E2, Hi/Lo stay 0x12/0x34.
- Start held high through RUN -> no restart. Start asserted in DONE -> second result after exactly 34 more edges.
- Reset pulse at E10 of a MULT -> all outputs 0 immediately, state IDLE, no `Done`. A new Start completes normally.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared state encoding, opcode constants and iteration count for the MULT/DIV sequencer
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} muldiv_state_t;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int MULDIV_ITER = 32;
endpackage

// File: rtl/muldiv_ctrl_neg_if.sv
// neg_if: combinational conditional two's-complement
//   a_i   in  W : value
//   neg_i in  1 : negate when high
//   y_o   out W : neg_i ? -a_i : a_i
module neg_if #(parameter int W = 32) (
  input  logic [W-1:0] a_i,
  input  logic         neg_i,
  output logic [W-1:0] y_o
);
  assign y_o = neg_i ? -a_i : a_i;
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle signed MULT/DIV sequencer owning the Hi/Lo registers
//   Clock/Reset         : rising-edge clock, async active-high reset
//   Start, Op, OpA, OpB : one-cycle request, 0=MULT 1=DIV, operands
//   Busy, Done, DivZero : in flight, completion pulse, zero-divisor flag with Done
//   Hi, Lo              : product halves, or remainder/quotient
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_ITER
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  muldiv_state_t state_q, state_d;
  logic op_q, op_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] abs_a, abs_b, quot_fix, rem_fix, sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0] sum, sh;
  logic ge;
  neg_if #(.W(WIDTH)) u_abs_a (.a_i(OpA), .neg_i(OpA[WIDTH-1]), .y_o(abs_a));
  neg_if #(.W(WIDTH)) u_abs_b (.a_i(OpB), .neg_i(OpB[WIDTH-1]), .y_o(abs_b));
  neg_if #(.W(2*WIDTH)) u_fix_p (.a_i(work_q), .neg_i(sa_q ^ sb_q), .y_o(prod_fix));
  neg_if #(.W(WIDTH)) u_fix_q (.a_i(work_q[WIDTH-1:0]), .neg_i(sa_q ^ sb_q), .y_o(quot_fix));
  neg_if #(.W(WIDTH)) u_fix_r (.a_i(work_q[2*WIDTH-1:WIDTH]), .neg_i(sa_q), .y_o(rem_fix));
  // a_q holds the multiplicand (MULT) or divisor (DIV); b_q holds the multiplier
  // (shifted right) or the dividend (shifted left, MSB feeding the remainder).
  assign sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q & {WIDTH{b_q[0]}}};
  assign sh = {work_q[2*WIDTH-1:WIDTH], b_q[WIDTH-1]};
  assign ge = sh >= {1'b0, a_q};
  // When ge holds the true difference fits in WIDTH bits, so the low bits suffice.
  assign sub = sh[WIDTH-1:0] - a_q;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    sa_d = sa_q;
    sb_d = sb_q;
    dz_d = dz_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    work_d = work_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          op_d = Op;
          sa_d = OpA[WIDTH-1];
          sb_d = OpB[WIDTH-1];
          a_d = (Op == OP_DIV) ? abs_b : abs_a;
          b_d = (Op == OP_DIV) ? abs_a : abs_b;
          work_d = '0;
          cnt_d = '0;
          dz_d = (Op == OP_DIV) && (OpB == '0);
          state_d = dz_d ? FIX : RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        work_d = (op_q == OP_MULT) ? {sum, work_q[WIDTH-1:1]}
                                   : {ge ? sub : sh[WIDTH-1:0], work_q[WIDTH-2:0], ge};
        b_d = (op_q == OP_MULT) ? b_q >> 1 : b_q << 1;
        state_d = (cnt_q == LAST) ? FIX : RUN;
      end
      default: begin
        hi_d = dz_q ? hi_q : (op_q == OP_MULT) ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
        lo_d = dz_q ? lo_q : (op_q == OP_MULT) ? prod_fix[WIDTH-1:0] : quot_fix;
        state_d = DONE;
      end
    endcase
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q <= OP_MULT;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      dz_q <= 1'b0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      work_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      dz_q <= dz_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      work_q <= work_d;
    end
  end
  assign Busy = (state_q == RUN) || (state_q == FIX);
  assign Done = state_q == DONE;
  assign DivZero = Done && dz_q;
  assign Hi = hi_q;
  assign Lo = lo_q;
endmodule
